// File: rtl/tm1637_frame_ctrl_pkg.sv
// Shared constants, state encoding and byte helpers for the TM1637 refresh sequencer.
package tm1637_frame_ctrl_pkg;

    localparam logic [7:0] CMD_DATA   = 8'h40;
    localparam logic [7:0] CMD_ADDR   = 8'hC0;
    localparam logic [7:0] CMD_CTRL   = 8'h80;
    localparam int         PHASES     = 4;
    localparam logic [1:0] LAST_FRAME = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_NEXT
    } state_t;

    // Index of the last byte in a frame: the address frame carries command + 4 digits.
    function automatic logic [2:0] frame_last_idx(input logic [1:0] frame);
        return (frame == 2'd1) ? 3'd4 : 3'd0;
    endfunction

    function automatic logic [7:0] ctrl_byte(input logic disp_on, input logic [2:0] bright);
        return CMD_CTRL | {4'b0000, disp_on, bright};
    endfunction

endpackage

// File: rtl/tm1637_tick_gen.sv
// Quarter-bit enable generator: one-cycle pulse every TICK_DIV cycles while enabled.
module tm1637_tick_gen
    import tm1637_frame_ctrl_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BIT_HZ = 100_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int TICK_DIV = CLK_HZ / (PHASES * BIT_HZ);
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (!i_en || cnt == TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (cnt == TC);

endmodule

// File: rtl/tm1637_frame_ctrl.sv
// TM1637 refresh sequencer: data cmd frame, address + 4 digits frame, display ctrl frame.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | bus released, waiting for i_start
// ST_START | 2 ticks: pull DIO low with CLK high, then drop CLK
// ST_BIT   | 4 ticks per bit, LSB first, DIO updated only while CLK low
// ST_ACK   | 4 ticks: release DIO, sample slave ACK on CLK high
// ST_STOP  | 4 ticks: DIO low, CLK high, DIO high, idle gap
// ST_NEXT  | zero-tick decision: next byte, next frame or finish
module tm1637_frame_ctrl
    import tm1637_frame_ctrl_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BIT_HZ = 100_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_digits,
    input  logic [2:0]  i_bright,
    input  logic        i_disp_on,
    input  logic        i_dio,
    output logic        o_scl,
    output logic        o_dio_oe,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ack_err
);

    state_t      state, state_nxt;
    logic [1:0]  phase, phase_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [2:0]  byte_idx, byte_nxt;
    logic [1:0]  frame_idx, frame_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        scl_q, scl_nxt;
    logic        dio_oe_q, dio_oe_nxt;
    logic        busy_q, busy_nxt;
    logic        done_q, done_nxt;
    logic        ack_err_q, ack_err_nxt;
    logic        accept;
    logic        tick;
    logic [31:0] digits_q;
    logic [2:0]  bright_q;
    logic        disp_on_q;
    logic [2:0]  load_idx;
    logic [7:0]  load_byte;

    tm1637_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .BIT_HZ (BIT_HZ)
    ) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (busy_q),
        .o_tick  (tick)
    );

    // NEXT preloads the following byte; START loads the first byte of its frame.
    assign load_idx = (state == ST_NEXT) ? byte_idx + 3'd1 : byte_idx;

    always_comb begin
        load_byte = CMD_DATA;
        case (frame_idx)
            2'd1: begin
                case (load_idx)
                    3'd0:    load_byte = CMD_ADDR;
                    3'd1:    load_byte = digits_q[7:0];
                    3'd2:    load_byte = digits_q[15:8];
                    3'd3:    load_byte = digits_q[23:16];
                    default: load_byte = digits_q[31:24];
                endcase
            end
            2'd2:    load_byte = ctrl_byte(disp_on_q, bright_q);
            default: load_byte = CMD_DATA;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        bit_nxt     = bit_idx;
        byte_nxt    = byte_idx;
        frame_nxt   = frame_idx;
        shreg_nxt   = shreg;
        scl_nxt     = scl_q;
        dio_oe_nxt  = dio_oe_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        ack_err_nxt = ack_err_q;
        accept      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                scl_nxt    = 1'b1;
                dio_oe_nxt = 1'b0;
                if (i_start) begin
                    accept      = 1'b1;
                    busy_nxt    = 1'b1;
                    ack_err_nxt = 1'b0;
                    phase_nxt   = 2'd0;
                    frame_nxt   = 2'd0;
                    byte_nxt    = 3'd0;
                    state_nxt   = ST_START;
                end
            end
            ST_START: if (tick) begin
                if (phase == 2'd0) begin
                    dio_oe_nxt = 1'b1;
                    phase_nxt  = 2'd1;
                end else begin
                    scl_nxt   = 1'b0;
                    shreg_nxt = load_byte;
                    bit_nxt   = 3'd0;
                    phase_nxt = 2'd0;
                    state_nxt = ST_BIT;
                end
            end
            ST_BIT: if (tick) begin
                phase_nxt = phase + 2'd1;
                case (phase)
                    2'd0: begin
                        scl_nxt    = 1'b0;
                        dio_oe_nxt = ~shreg[0];
                    end
                    2'd2: scl_nxt = 1'b1;
                    2'd3: begin
                        shreg_nxt = {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) state_nxt = ST_ACK;
                        else                 bit_nxt   = bit_idx + 3'd1;
                    end
                    default: ;
                endcase
            end
            ST_ACK: if (tick) begin
                phase_nxt = phase + 2'd1;
                case (phase)
                    2'd0: begin
                        scl_nxt    = 1'b0;
                        dio_oe_nxt = 1'b0;
                    end
                    2'd2: begin
                        scl_nxt = 1'b1;
                        if (i_dio) ack_err_nxt = 1'b1;
                    end
                    2'd3: state_nxt = (byte_idx == frame_last_idx(frame_idx)) ? ST_STOP : ST_NEXT;
                    default: ;
                endcase
            end
            ST_STOP: if (tick) begin
                phase_nxt = phase + 2'd1;
                case (phase)
                    2'd0: begin
                        scl_nxt    = 1'b0;
                        dio_oe_nxt = 1'b1;
                    end
                    2'd1: scl_nxt    = 1'b1;
                    2'd2: dio_oe_nxt = 1'b0;
                    default: state_nxt = ST_NEXT;
                endcase
            end
            ST_NEXT: begin
                if (byte_idx != frame_last_idx(frame_idx)) begin
                    byte_nxt  = byte_idx + 3'd1;
                    shreg_nxt = load_byte;
                    bit_nxt   = 3'd0;
                    state_nxt = ST_BIT;
                end else if (frame_idx == LAST_FRAME) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    frame_nxt = frame_idx + 2'd1;
                    byte_nxt  = 3'd0;
                    state_nxt = ST_START;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            phase     <= 2'd0;
            bit_idx   <= 3'd0;
            byte_idx  <= 3'd0;
            frame_idx <= 2'd0;
            shreg     <= 8'h00;
            scl_q     <= 1'b1;
            dio_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            bit_idx   <= bit_nxt;
            byte_idx  <= byte_nxt;
            frame_idx <= frame_nxt;
            shreg     <= shreg_nxt;
            scl_q     <= scl_nxt;
            dio_oe_q  <= dio_oe_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            ack_err_q <= ack_err_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            digits_q  <= 32'h0;
            bright_q  <= 3'd0;
            disp_on_q <= 1'b0;
        end else if (accept) begin
            digits_q  <= i_digits;
            bright_q  <= i_bright;
            disp_on_q <= i_disp_on;
        end
    end

    assign o_scl     = scl_q;
    assign o_dio_oe  = dio_oe_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_ack_err = ack_err_q;

endmodule

// File: tb/tb_tm1637_frame_ctrl.sv
// Bench for tm1637_frame_ctrl: vector table plus random refreshes against a bus-level TM1637 slave.
module tb_tm1637_frame_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_digits = 32'h0;
    logic [2:0]  i_bright = 3'd0;
    logic        i_disp_on = 1'b0;
    logic        i_dio;
    logic        o_scl, o_dio_oe, o_busy, o_done, o_ack_err;

    int checks = 0;
    int errors = 0;

    tm1637_frame_ctrl #(
        .CLK_HZ (1600),
        .BIT_HZ (100)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_digits  (i_digits),
        .i_bright  (i_bright),
        .i_disp_on (i_disp_on),
        .i_dio     (i_dio),
        .o_scl     (o_scl),
        .o_dio_oe  (o_dio_oe),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_ack_err (o_ack_err)
    );

    always #5 i_clk = ~i_clk;

    // Bus-functional slave: wired-AND DIO, decodes bytes on CLK rising edges, ACKs unless masked.
    logic       slave_ack = 1'b0;
    logic [6:0] nack_mask = 7'h00;
    int         byte_base = 0;
    logic [7:0] byte_q[$];
    int         frame_q[$];
    int         starts = 0, stops = 0, viol = 0;
    logic       prev_scl = 1'b1, prev_line = 1'b1, in_frame = 1'b0;
    int         bitcnt = 0, fbytes = 0, ack_idx = 0;
    logic [7:0] mon_sh = 8'h00;

    assign i_dio = !o_dio_oe && !slave_ack;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_scl = 1'b1; prev_line = 1'b1; in_frame = 1'b0;
            slave_ack = 1'b0; bitcnt = 0; fbytes = 0;
        end else begin
            if (i_dio != prev_line) begin
                if (prev_scl && o_scl) begin
                    if (!i_dio) begin
                        if (in_frame) viol++;
                        in_frame = 1'b1; bitcnt = 0; fbytes = 0; starts++;
                    end else begin
                        if (!in_frame) viol++;
                        in_frame = 1'b0; stops++;
                        frame_q.push_back(fbytes);
                    end
                end else if (!prev_scl && o_scl) begin
                    viol++;
                end
            end
            if (!prev_scl && o_scl && in_frame) begin
                if (bitcnt < 8) begin
                    mon_sh = {i_dio, mon_sh[7:1]};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        byte_q.push_back(mon_sh);
                        fbytes++;
                    end
                end else if (bitcnt == 8) begin
                    bitcnt = 9;
                end
            end
            if (prev_scl && !o_scl && in_frame) begin
                if (bitcnt == 8) begin
                    ack_idx = byte_q.size() - 1 - byte_base;
                    slave_ack = (ack_idx >= 0 && ack_idx < 7) ? !nack_mask[ack_idx] : 1'b1;
                end else if (bitcnt == 9) begin
                    slave_ack = 1'b0;
                    bitcnt = 0;
                end
            end
            prev_scl  = o_scl;
            prev_line = i_dio;
        end
    end

    typedef struct {
        logic [31:0] digits;
        logic [2:0]  bright;
        logic        on;
        logic [6:0]  nack;
        bit          poke;
        logic [7:0]  exp_ctrl;
        logic        exp_err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: 40 | C0 d0 d1 d2 d3 | ctrl, byte k at [8k+:8].
    function automatic logic [55:0] model_bytes(input vec_t v);
        return {v.exp_ctrl, v.digits, 8'hC0, 8'h40};
    endfunction

    task automatic do_txn(input vec_t v, input bit wait_first);
        int cyc, bb, fb, sb, pb, vb;
        logic [55:0] exp_b;
        if (wait_first) begin
            @(negedge i_clk);
            chk("done_width", int'(o_done), 0);
        end
        bb = byte_q.size(); fb = frame_q.size();
        sb = starts; pb = stops; vb = viol;
        byte_base = bb;
        nack_mask = v.nack;
        i_digits  = v.digits;
        i_bright  = v.bright;
        i_disp_on = v.on;
        i_start   = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("busy_after_accept", int'(o_busy), 1);
        chk("ack_err_cleared", int'(o_ack_err), 0);
        cyc = 0;
        while (!o_done && cyc < 1200) begin
            @(negedge i_clk);
            cyc++;
            if (v.poke && cyc == 500) begin
                i_start = 1'b1; i_digits = ~v.digits; i_bright = ~v.bright;
            end else if (v.poke && cyc == 501) begin
                i_start = 1'b0;
            end
        end
        chk("done_latency", cyc, 1081);
        chk("busy_at_done", int'(o_busy), 0);
        chk("ack_err", int'(o_ack_err), int'(v.exp_err));
        chk("byte_count", byte_q.size() - bb, 7);
        exp_b = model_bytes(v);
        if (byte_q.size() - bb == 7)
            for (int k = 0; k < 7; k++)
                chk($sformatf("byte%0d", k), int'(byte_q[bb + k]), int'(exp_b[8*k +: 8]));
        chk("frame_count", frame_q.size() - fb, 3);
        if (frame_q.size() - fb == 3) begin
            chk("frame0_len", frame_q[fb], 1);
            chk("frame1_len", frame_q[fb + 1], 5);
            chk("frame2_len", frame_q[fb + 2], 1);
        end
        chk("starts", starts - sb, 3);
        chk("stops", stops - pb, 3);
        chk("protocol_viol", viol - vb, 0);
    endtask

    initial begin
        tbl[0] = '{32'h4F5B063F, 3'd7, 1'b1, 7'h00, 1'b0, 8'h8F, 1'b0};
        tbl[1] = '{32'h4F5B063F, 3'd7, 1'b1, 7'h08, 1'b0, 8'h8F, 1'b1};
        tbl[2] = '{32'h12345678, 3'd5, 1'b1, 7'h00, 1'b1, 8'h8D, 1'b0};
        tbl[3] = '{32'hA5C30FF0, 3'd2, 1'b0, 7'h00, 1'b0, 8'h82, 1'b0};
        tbl[4] = '{32'hFFFFFFFF, 3'd0, 1'b1, 7'h7F, 1'b0, 8'h88, 1'b1};
        for (int i = 5; i < 10; i++) begin
            tbl[i].digits   = $urandom;
            tbl[i].bright   = 3'($urandom_range(0, 7));
            tbl[i].on       = 1'($urandom_range(0, 1));
            tbl[i].nack     = ($urandom_range(0, 1) == 1) ? 7'(1 << $urandom_range(0, 6)) : 7'h00;
            tbl[i].poke     = 1'b0;
            tbl[i].exp_ctrl = 8'(128 + 8 * int'(tbl[i].on) + int'(tbl[i].bright));
            tbl[i].exp_err  = (tbl[i].nack != 7'h00);
        end

        repeat (3) @(negedge i_clk);
        chk("rst_scl", int'(o_scl), 1);
        chk("rst_dio_oe", int'(o_dio_oe), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_ack_err", int'(o_ack_err), 0);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("idle_scl", int'(o_scl), 1);
        chk("idle_dio_oe", int'(o_dio_oe), 0);
        chk("idle_busy", int'(o_busy), 0);

        // Entry 4 is accepted in the o_done cycle of entry 3.
        for (int i = 0; i < 10; i++)
            do_txn(tbl[i], i != 4);

        @(negedge i_clk);
        i_digits = 32'h4F5B063F; i_bright = 3'd7; i_disp_on = 1'b1;
        nack_mask = 7'h00; byte_base = byte_q.size();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (600) @(negedge i_clk);
        chk("midf1_busy_before_rst", int'(o_busy), 1);
        i_rst_n = 1'b0;
        #1;
        chk("midf1_rst_scl", int'(o_scl), 1);
        chk("midf1_rst_dio_oe", int'(o_dio_oe), 0);
        chk("midf1_rst_busy", int'(o_busy), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("post_rst_scl", int'(o_scl), 1);

        do_txn(tbl[0], 1'b1);

        repeat (5) @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
